// File: rtl/round_controller.sv
// round_controller: sequences NUM_STEPS timed LED windows against an external delay timer.
// Define ROUND_MISS_PENALTY_EN to decrement the score (floored at 0) on missed windows.
module round_controller #(
  parameter int         NUM_STEPS = 8,
  parameter int         STEP_W    = 4,
  parameter int         LED_W     = 4,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               clock_done,
  input  logic [LED_W-1:0]   btn,
  output logic               start_clock,
  output logic [LED_W-1:0]   led,
  output logic [STEP_W-1:0]  step,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               round_done
);
  localparam int                 IDX_W = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [7:0]         SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [STEP_W-1:0]  LAST  = STEP_W'(NUM_STEPS - 1);
  localparam logic [SCORE_W-1:0] SMAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_GAP, S_FINISH} state_t;

  state_t             r_state;
  logic               r_go_q, r_hit_taken, r_start_clock, r_busy, r_round_done;
  logic [7:0]         r_lfsr;
  logic [LED_W-1:0]   r_led;
  logic [STEP_W-1:0]  r_step;
  logic [SCORE_W-1:0] r_score;

  logic               w_go_edge, w_press, w_match, w_fb;
  logic [IDX_W-1:0]   w_idx;
  logic [SCORE_W-1:0] w_score_inc, w_score_dec;

  assign w_go_edge   = go & ~r_go_q;
  assign w_press     = (btn != '0) && !r_hit_taken;
  assign w_match     = (btn == r_led);
  assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_idx       = r_lfsr[IDX_W-1:0];
  assign w_score_inc = (r_score == SMAX) ? r_score : r_score + 1'b1;
  assign w_score_dec = (r_score == '0) ? r_score : r_score - 1'b1;

  assign start_clock = r_start_clock;
  assign led         = r_led;
  assign step        = r_step;
  assign score       = r_score;
  assign busy        = r_busy;
  assign round_done  = r_round_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_go_q        <= 1'b0;
      r_hit_taken   <= 1'b0;
      r_start_clock <= 1'b0;
      r_busy        <= 1'b0;
      r_round_done  <= 1'b0;
      r_lfsr        <= SEED;
      r_led         <= '0;
      r_step        <= '0;
      r_score       <= '0;
    end else begin
      r_go_q <= go;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (w_go_edge) begin
            r_score      <= '0;
            r_step       <= '0;
            r_round_done <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_led         <= LED_W'(1) << w_idx;
          r_lfsr        <= {r_lfsr[6:0], w_fb};
          r_hit_taken   <= 1'b0;
          r_busy        <= 1'b1;
          r_start_clock <= 1'b1;
          r_state       <= S_ARM;
        end
        S_ARM: begin
          // Press is scored even in the cycle clock_done closes the window.
          if (w_press) begin
            r_hit_taken <= 1'b1;
            if (w_match) r_score <= w_score_inc;
`ifdef ROUND_MISS_PENALTY_EN
            else r_score <= w_score_dec;
`endif
          end
          if (clock_done) begin
            r_start_clock <= 1'b0;
            r_led         <= '0;
            r_state       <= S_GAP;
          end
        end
        S_GAP: begin
`ifdef ROUND_MISS_PENALTY_EN
          if (!r_hit_taken) r_score <= w_score_dec;
`endif
          if (r_step == LAST) begin
            r_busy       <= 1'b0;
            r_round_done <= 1'b1;
            r_state      <= S_FINISH;
          end else begin
            r_step  <= r_step + 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_controller.sv
// Randomized bench for round_controller: timer model plus window-level reference of LEDs and score.
module tb_round_controller;
  localparam int NS  = 8;
  localparam int STW = 4;
  localparam int LW  = 4;
  localparam int SW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           go = 1'b0;
  logic           cd_force = 1'b0;
  logic           clock_done;
  logic [LW-1:0]  btn = '0;
  logic           start_clock;
  logic [LW-1:0]  led;
  logic [STW-1:0] step;
  logic [SW-1:0]  score;
  logic           busy;
  logic           round_done;

  int         tcnt = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_lfsr = 8'hA5;
  int         m_score = 0;

  round_controller #(.NUM_STEPS(NS), .STEP_W(STW), .LED_W(LW), .SCORE_W(SW), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .go(go), .clock_done(clock_done), .btn(btn),
    .start_clock(start_clock), .led(led), .step(step), .score(score),
    .busy(busy), .round_done(round_done)
  );

  always #5 clk = ~clk;

  // Timer model: clock_done rises 5 cycles after start_clock rises, clears when start_clock drops.
  always @(posedge clk) begin
    if (!start_clock) tcnt <= 0;
    else if (tcnt < 31) tcnt <= tcnt + 1;
  end
  assign clock_done = (start_clock && tcnt >= 5) || cd_force;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Plans: 0 none, 1 hit, 2 wrong then right, 3 hit with clock_done, 4 wrong, 5 hit then wrong.
  function automatic logic [LW-1:0] plan_btn(input int p, input int c,
                                             input logic [LW-1:0] el, input logic [LW-1:0] wr);
    case (p)
      1: return (c == 1) ? el : '0;
      2: return (c == 1) ? wr : ((c == 2) ? el : '0);
      3: return (c == 5) ? el : '0;
      4: return (c == 2) ? wr : '0;
      5: return (c == 0) ? el : ((c == 3) ? wr : '0);
      default: return '0;
    endcase
  endfunction

  task automatic run_round(input bit hold, input int mode);
    int lat, c, low, p;
    logic [LW-1:0] el, wr;
    go = 1'b1;
    tick();
    lat = 1;
    if (!hold) go = 1'b0;
    chk("load_score", score, 0);
    chk("load_step", step, 0);
    chk("load_sc", start_clock, 0);
    while (!start_clock && lat < 10) begin tick(); lat++; end
    chk("go_latency", lat, 2);
    m_score = 0;
    for (int k = 0; k < NS; k++) begin
      el = LW'(1 << (m_lfsr % LW));
      m_lfsr = lfsr_step(m_lfsr);
      wr = {el[LW-2:0], el[LW-1]};
      p = (mode == 2) ? int'($urandom_range(0, 5)) : mode;
      chk("win_led", led, el);
      chk("win_step", step, k);
      chk("win_busy", busy, 1);
      c = 0;
      while (start_clock && c < 20) begin
        btn = plan_btn(p, c, el, wr);
        tick();
        c++;
      end
      btn = '0;
      if (p == 1 || p == 3 || p == 5) begin
        if (m_score < 255) m_score++;
      end
`ifdef ROUND_MISS_PENALTY_EN
      else if (m_score > 0) m_score--;
`endif
      chk("win_len", c, 6);
      chk("gap_led", led, 0);
      chk("gap_score", score, m_score);
      if (k < NS - 1) begin
        low = 0;
        while (!start_clock && low < 10) begin low++; tick(); end
        chk("gap_low", low, 2);
      end else begin
        tick();
        chk("fin_done", round_done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_step", step, NS - 1);
        chk("fin_score", score, m_score);
        chk("fin_sc", start_clock, 0);
        chk("fin_led", led, 0);
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sc"}, start_clock, 0);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, round_done, 0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk_idle_outputs("rst");
    rst = 1'b1;
    tick();

    // clock_done outside ARM must not move the block
    cd_force = 1'b1;
    repeat (3) tick();
    cd_force = 1'b0;
    chk("idle_cd_busy", busy, 0);
    chk("idle_cd_sc", start_clock, 0);
    tick();

    run_round(1'b0, 0);
    cd_force = 1'b1;
    repeat (2) tick();
    cd_force = 1'b0;
    chk("fin_cd_done", round_done, 1);
    chk("fin_cd_sc", start_clock, 0);

    run_round(1'b0, 1);
    tick();
    run_round(1'b1, 2);
    repeat (4) tick();
    chk("hold_no_retrig_sc", start_clock, 0);
    chk("hold_no_retrig_done", round_done, 1);
    go = 1'b0;
    tick();

    // Abort a round mid-window with some score accumulated
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (!(start_clock && step == 3) && n < 80) begin
      btn = start_clock ? led : '0;
      tick();
      n++;
    end
    chk("abort_reach", (n < 80) ? 1 : 0, 1);
    btn = led;
    tick();
    btn = '0;
    tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("abort");
    tick();
    rst = 1'b1;
    m_lfsr = 8'hA5;
    tick();
    run_round(1'b0, 2);

    repeat (3) begin
      tick();
      run_round(1'b0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
